// File: rtl/gun_pkg.sv
// Shared light-gun definitions: sequencer state encoding, status word layout and timing defaults.
// Consumed by every light-gun channel and the debounce helper.
package gun_pkg;

  typedef logic [2:0] gun_state_t;

  localparam gun_state_t S_IDLE     = 3'd0;
  localparam gun_state_t S_ARM      = 3'd1;
  localparam gun_state_t S_BLACK    = 3'd2;
  localparam gun_state_t S_TARGET   = 3'd3;
  localparam gun_state_t S_COOLDOWN = 3'd4;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int SETTLE_CYCLES_DEF   = 1000;
  localparam int COOLDOWN_FRAMES_DEF = 4;

  typedef struct packed {
    logic shot;
    logic hit;
  } gun_status_t;

endpackage

// File: rtl/lightgun_channel_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and registered press pulse.
// press fires 2 + DEBOUNCE_CYCLES cycles after a clean raw rising edge; no backpressure.
module debounce
  import gun_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DB_W            = 19
) (
  input  logic CLK,
  input  logic CLR,
  input  logic raw,
  output logic press
);

  logic            sync_m;
  logic            sync_s;
  logic            level;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync_m <= 1'b0;
      sync_s <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_m <= raw;
      sync_s <= sync_m;
      press  <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (sync_s == level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
        press <= ~level;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/lightgun_channel.sv
// One player's light-gun channel: debounced trigger starts a black/target flash sequence, sensor yields sticky shot/hit.
// Flash outputs are registered; a press outside IDLE is dropped rather than queued.
module lightgun_channel
  import gun_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DB_W            = 19,
  parameter int SETTLE_CYCLES   = SETTLE_CYCLES_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
  parameter int CD_W            = 3
) (
  input  logic CLK,
  input  logic CLR,
  input  logic trigger_raw,
  input  logic sens_raw,
  input  logic frame_start,
  input  logic rd_clear,
  output logic shot,
  output logic hit,
  output logic flash_black,
  output logic flash_target,
  output logic busy
);

  localparam int ST_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  logic            press;
  logic            sens_m;
  logic            sens_s;
  gun_state_t      state;
  logic            blocked;
  logic            seen;
  logic [ST_W-1:0] settle;
  logic [CD_W-1:0] cd;
  gun_status_t     status;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_trig_db (
    .CLK  (CLK),
    .CLR  (CLR),
    .raw  (trigger_raw),
    .press(press)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sens_m <= 1'b0;
      sens_s <= 1'b0;
    end else begin
      sens_m <= sens_raw;
      sens_s <= sens_m;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state        <= S_IDLE;
      flash_black  <= 1'b0;
      flash_target <= 1'b0;
      blocked      <= 1'b0;
      seen         <= 1'b0;
      settle       <= '0;
      cd           <= '0;
      status       <= '0;
    end else begin
      // A status set later in this block overrides the CPU clear.
      if (rd_clear) begin
        status <= '0;
      end
      case (state)
        S_IDLE: begin
          if (press) begin
            state <= S_ARM;
          end
        end
        S_ARM: begin
          if (frame_start) begin
            state       <= S_BLACK;
            blocked     <= 1'b0;
            flash_black <= 1'b1;
          end
        end
        S_BLACK: begin
          if (sens_s) begin
            blocked <= 1'b1;
          end
          if (frame_start) begin
            state        <= S_TARGET;
            settle       <= '0;
            flash_black  <= 1'b0;
            flash_target <= 1'b1;
          end
        end
        S_TARGET: begin
          // Ignore the sensor until the display has had time to show the target.
          if (settle != ST_W'(SETTLE_CYCLES)) begin
            settle <= settle + ST_W'(1);
          end else if (sens_s && !blocked) begin
            seen <= 1'b1;
          end
          if (frame_start) begin
            state        <= S_COOLDOWN;
            flash_target <= 1'b0;
            status.shot  <= 1'b1;
            status.hit   <= seen;
            seen         <= 1'b0;
            cd           <= CD_W'(COOLDOWN_FRAMES);
          end
        end
        S_COOLDOWN: begin
          if (cd == '0) begin
            state <= S_IDLE;
          end else if (frame_start) begin
            if (cd == CD_W'(1)) begin
              state <= S_IDLE;
            end
            cd <= cd - CD_W'(1);
          end
        end
        default: begin
          state        <= S_IDLE;
          flash_black  <= 1'b0;
          flash_target <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign shot = status.shot;
  assign hit  = status.hit;

endmodule
